// File: rtl/popcount_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : popcount_pkg                                                 |
// | Description : Shared types and elaboration helpers for popcount_pipe.      |
// |               - stages_f : number of register stages in the reduction tree |
// |               - cnt_w_f  : width needed to hold a count of 0..WIDTH        |
// |               - popcount_sb_t : sideband that travels with each beat       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package popcount_pkg;

  // Per-beat control information carried alongside the partial sums.
  typedef struct packed {
    logic valid;
    logic zeros;
    logic last;
  } popcount_sb_t;

  // One register stage per LPS adder levels, rounded up so the final level
  // always ends on a register.
  function automatic int stages_f(input int width, input int lps);
    int levels;
    levels = $clog2(width);
    return (levels + lps - 1) / lps;
  endfunction

  function automatic int cnt_w_f(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_tree_lvl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : popcount_tree_lvl                                            |
// | Description : One combinational level of the popcount adder tree.         |
// |               Adds adjacent pairs of IN_W-bit partial sums into N_OUT      |
// |               partial sums of IN_W+1 bits, so no carry is ever lost.       |
// | Ports       : in_sums  [2*N_OUT*IN_W]   packed input partials, pair j at   |
// |                                          slots 2j and 2j+1                 |
// |               out_sums [N_OUT*(IN_W+1)] packed output partials             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module popcount_tree_lvl
  import popcount_pkg::*;
#(
  parameter int IN_W  = 1,
  parameter int N_OUT = 1
) (
  input  logic [2*N_OUT*IN_W-1:0]   in_sums,
  output logic [N_OUT*(IN_W+1)-1:0] out_sums
);

  for (genvar j = 0; j < N_OUT; j++) begin : g_pair
    logic [IN_W:0] w_a;
    logic [IN_W:0] w_b;

    assign w_a = {1'b0, in_sums[(2*j)*IN_W   +: IN_W]};
    assign w_b = {1'b0, in_sums[(2*j+1)*IN_W +: IN_W]};
    assign out_sums[j*(IN_W+1) +: (IN_W+1)] = w_a + w_b;
  end

endmodule
`default_nettype wire

// File: rtl/popcount_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : popcount_pipe                                                |
// | Description : Pipelined population counter with valid/ready on both       |
// |               sides. Stage 0 registers the (optionally inverted) word,     |
// |               then a balanced adder tree is registered every               |
// |               LEVELS_PER_STAGE levels; the last tree register drives the   |
// |               outputs. Latency is STAGES clocks after acceptance.          |
// |               The whole pipe advances together on en = !out_valid ||       |
// |               out_ready; bubbles are kept.                                 |
// | Ports       : clk, rst        clock, synchronous active-high reset         |
// |               in_valid/ready  input handshake (in_ready = en)              |
// |               in_data [WIDTH] word to count                                |
// |               in_zeros        1 = count zeros for this beat                |
// |               in_last         frame end (accumulator build only)           |
// |               out_valid/ready result handshake                             |
// |               out_count[CNT_W] per-beat count                              |
// |               out_acc [ACC_W] running frame sum incl. current beat         |
// |               out_sat         frame saturated (accumulator build only)     |
// | Config      : define POPCOUNT_PIPE_ACCUM_EN to add the frame accumulator   |
// |               (in_last, out_acc, out_sat, ACC_W).                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module popcount_pipe
  import popcount_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 2,
`ifdef POPCOUNT_PIPE_ACCUM_EN
  parameter int ACC_W            = 16,
`endif
  localparam int CNT_W           = cnt_w_f(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_zeros,
`ifdef POPCOUNT_PIPE_ACCUM_EN
  input  logic             in_last,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count
`ifdef POPCOUNT_PIPE_ACCUM_EN
  ,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat
`endif
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int PAD_W  = 1 << LEVELS;
  localparam int STAGES = stages_f(WIDTH, LEVELS_PER_STAGE);

  // --------------------------------------------------------------------------
  // Global enable: every register in the pipe moves or holds together.
  // --------------------------------------------------------------------------
  logic w_en;

  assign w_en      = !out_valid || out_ready;
  assign in_ready  = w_en;

  // --------------------------------------------------------------------------
  // Sideband pipe: index 0 is the input register, index STAGES the output.
  // --------------------------------------------------------------------------
  popcount_sb_t r_sb [0:STAGES];
  popcount_sb_t w_sb_in;

  always_comb begin
    w_sb_in       = '0;
    w_sb_in.valid = in_valid;
    w_sb_in.zeros = in_zeros;
`ifdef POPCOUNT_PIPE_ACCUM_EN
    w_sb_in.last  = in_last;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s <= STAGES; s++) begin
        r_sb[s] <= '0;
      end
    end else if (w_en) begin
      r_sb[0] <= w_sb_in;
      for (int s = 1; s <= STAGES; s++) begin
        r_sb[s] <= r_sb[s-1];
      end
    end
  end

  assign out_valid = r_sb[STAGES].valid;

  // --------------------------------------------------------------------------
  // Stage 0: invert for zeros mode and zero-pad to a power of two. Padding
  // bits are zero after the XOR so they never contribute to the count.
  // --------------------------------------------------------------------------
  logic [PAD_W-1:0] w_bits;
  logic [PAD_W-1:0] r_bits;

  always_comb begin
    w_bits              = '0;
    w_bits[WIDTH-1:0]   = in_data ^ {WIDTH{in_zeros}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bits <= '0;
    end else if (w_en) begin
      r_bits <= w_bits;
    end
  end

  // --------------------------------------------------------------------------
  // Adder tree. Level k holds PAD_W>>k partials of k+1 bits. A register is
  // placed after every LEVELS_PER_STAGE levels and always after the last one.
  // --------------------------------------------------------------------------
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int N_OUT = PAD_W >> k;

    logic [2*N_OUT*k-1:0]   lvl_in;
    logic [N_OUT*(k+1)-1:0] lvl_sum;
    logic [N_OUT*(k+1)-1:0] lvl_out;

    if (k == 1) begin : g_src_bits
      assign lvl_in = r_bits;
    end else begin : g_src_prev
      assign lvl_in = g_lvl[k-1].lvl_out;
    end

    popcount_tree_lvl #(
      .IN_W  (k),
      .N_OUT (N_OUT)
    ) u_lvl (
      .in_sums  (lvl_in),
      .out_sums (lvl_sum)
    );

    if (((k % LEVELS_PER_STAGE) == 0) || (k == LEVELS)) begin : g_reg
      logic [N_OUT*(k+1)-1:0] r_sum;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_sum <= '0;
        end else if (w_en) begin
          r_sum <= lvl_sum;
        end
      end

      assign lvl_out = r_sum;
    end else begin : g_comb
      assign lvl_out = lvl_sum;
    end
  end

  // The root is LEVELS+1 bits; for non power-of-two widths the top bit can
  // never be set (count <= WIDTH), so CNT_W bits hold every value.
  assign out_count = g_lvl[LEVELS].lvl_out[CNT_W-1:0];

  // Fields and bits that are carried for uniformity but not consumed.
  logic [STAGES:0] w_unused_sb;
  logic            w_unused_root;

  for (genvar s = 0; s <= STAGES; s++) begin : g_sb_unused
    assign w_unused_sb[s] = r_sb[s].zeros ^ r_sb[s].last;
  end

  assign w_unused_root = ^g_lvl[LEVELS].lvl_out;

`ifdef POPCOUNT_PIPE_ACCUM_EN
  // --------------------------------------------------------------------------
  // Frame accumulator, updated only when a result is consumed so a stalled
  // beat is added exactly once. out_acc already includes the beat on the
  // output so downstream sees the running total without waiting a cycle.
  // --------------------------------------------------------------------------
  localparam int SUM_W = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;

  logic [ACC_W-1:0] r_acc;
  logic             r_sat;
  logic [SUM_W-1:0] w_sum;
  logic             w_ovf;
  logic [ACC_W-1:0] w_acc_next;

  assign w_sum      = SUM_W'(r_acc) + SUM_W'(out_count);
  assign w_ovf      = |w_sum[SUM_W-1:ACC_W];
  assign w_acc_next = w_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

  assign out_acc    = w_acc_next;
  assign out_sat    = r_sat | w_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (out_valid && out_ready) begin
      if (r_sb[STAGES].last) begin
        r_acc <= '0;
        r_sat <= 1'b0;
      end else begin
        r_acc <= w_acc_next;
        r_sat <= r_sat | w_ovf;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_popcount_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_popcount_pipe                                             |
// | Description : Scoreboard bench for popcount_pipe. Three instances:         |
// |               A: WIDTH=32/LPS=2 (3 stages) for directed tests,             |
// |               B: WIDTH=7/LPS=1 (3 stages), C: WIDTH=64/LPS=3 (2 stages)    |
// |               for random sweeps. Expected counts are queued on accept      |
// |               and compared when the result is consumed.                    |
// | Config      : POPCOUNT_PIPE_ACCUM_EN adds the frame accumulator checks.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_popcount_pipe;

  localparam int STG_A = 3;
  localparam int STG_B = 3;
  localparam int STG_C = 2;
  localparam int ACC_MAX_A = 63;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A
  logic        a_in_valid = 1'b0, a_in_ready, a_in_zeros = 1'b0;
  logic [31:0] a_in_data = '0;
  logic        a_out_valid, a_out_ready = 1'b1;
  logic [5:0]  a_out_count;
  logic        a_in_last = 1'b0;
  // DUT B
  logic        b_in_valid = 1'b0, b_in_ready, b_in_zeros = 1'b0;
  logic [6:0]  b_in_data = '0;
  logic        b_out_valid, b_out_ready = 1'b1;
  logic [2:0]  b_out_count;
  // DUT C
  logic        c_in_valid = 1'b0, c_in_ready, c_in_zeros = 1'b0;
  logic [63:0] c_in_data = '0;
  logic        c_out_valid, c_out_ready = 1'b1;
  logic [6:0]  c_out_count;
`ifdef POPCOUNT_PIPE_ACCUM_EN
  logic [5:0]  a_out_acc;
  logic        a_out_sat;
  logic [15:0] b_out_acc, c_out_acc;
  logic        b_out_sat, c_out_sat;
`endif

  popcount_pipe #(
    .WIDTH (32), .LEVELS_PER_STAGE (2)
`ifdef POPCOUNT_PIPE_ACCUM_EN
    , .ACC_W (6)
`endif
  ) u_dut_a (
    .clk (clk), .rst (rst),
    .in_valid (a_in_valid), .in_ready (a_in_ready),
    .in_data (a_in_data), .in_zeros (a_in_zeros),
`ifdef POPCOUNT_PIPE_ACCUM_EN
    .in_last (a_in_last),
`endif
    .out_valid (a_out_valid), .out_ready (a_out_ready),
    .out_count (a_out_count)
`ifdef POPCOUNT_PIPE_ACCUM_EN
    , .out_acc (a_out_acc), .out_sat (a_out_sat)
`endif
  );

  popcount_pipe #(.WIDTH (7), .LEVELS_PER_STAGE (1)) u_dut_b (
    .clk (clk), .rst (rst),
    .in_valid (b_in_valid), .in_ready (b_in_ready),
    .in_data (b_in_data), .in_zeros (b_in_zeros),
`ifdef POPCOUNT_PIPE_ACCUM_EN
    .in_last (1'b0),
`endif
    .out_valid (b_out_valid), .out_ready (b_out_ready),
    .out_count (b_out_count)
`ifdef POPCOUNT_PIPE_ACCUM_EN
    , .out_acc (b_out_acc), .out_sat (b_out_sat)
`endif
  );

  popcount_pipe #(.WIDTH (64), .LEVELS_PER_STAGE (3)) u_dut_c (
    .clk (clk), .rst (rst),
    .in_valid (c_in_valid), .in_ready (c_in_ready),
    .in_data (c_in_data), .in_zeros (c_in_zeros),
`ifdef POPCOUNT_PIPE_ACCUM_EN
    .in_last (1'b0),
`endif
    .out_valid (c_out_valid), .out_ready (c_out_ready),
    .out_count (c_out_count)
`ifdef POPCOUNT_PIPE_ACCUM_EN
    , .out_acc (c_out_acc), .out_sat (c_out_sat)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboards (sampled on negedge, act at next posedge) ---
  int   q_a[$], qe_a[$], q_b[$], qe_b[$], q_c[$], qe_c[$];
  bit   ql_a[$];
  bit   a_lat_chk = 1'b1;
  bit   a_hold_v = 1'b0;
  logic [5:0] a_hold_cnt = '0;
  int   m_acc = 0;
  bit   m_sat = 1'b0;

  always @(negedge clk) begin
    int   exp_c, exp_e, sum;
    bit   l, ovf;
    logic [31:0] t;
    if (rst) begin
      q_a.delete(); qe_a.delete(); ql_a.delete();
      a_hold_v = 1'b0; m_acc = 0; m_sat = 1'b0;
    end else begin
      if (a_hold_v) begin
        check("a_valid_hold", a_out_valid, 1);
        check("a_count_stable", a_out_count, a_hold_cnt);
      end
      if (a_out_valid && !a_out_ready) check("a_in_ready_stall", a_in_ready, 0);
      a_hold_v   = a_out_valid && !a_out_ready;
      a_hold_cnt = a_out_count;
      if (a_out_valid && a_out_ready) begin
        if (q_a.size() == 0) check("a_spurious_out", 1, 0);
        else begin
          exp_c = q_a.pop_front(); exp_e = qe_a.pop_front(); l = ql_a.pop_front();
          check("a_count", a_out_count, exp_c);
          if (a_lat_chk) check("a_latency", cyc - exp_e, STG_A);
          sum = m_acc + exp_c;
          ovf = (sum > ACC_MAX_A);
          if (ovf) sum = ACC_MAX_A;
`ifdef POPCOUNT_PIPE_ACCUM_EN
          check("a_acc", a_out_acc, sum);
          check("a_sat", a_out_sat, m_sat | ovf);
`endif
          if (l) begin m_acc = 0; m_sat = 1'b0; end
          else   begin m_acc = sum; m_sat = m_sat | ovf; end
        end
      end
      if (a_in_valid && a_in_ready) begin
        t = a_in_data ^ {32{a_in_zeros}};
        q_a.push_back($countones(t)); qe_a.push_back(cyc + 1); ql_a.push_back(a_in_last);
      end
    end
  end

  always @(negedge clk) begin
    logic [6:0]  tb;
    logic [63:0] tc;
    if (rst) begin
      q_b.delete(); qe_b.delete(); q_c.delete(); qe_c.delete();
    end else begin
      if (b_out_valid && b_out_ready) begin
        if (q_b.size() == 0) check("b_spurious_out", 1, 0);
        else begin
          check("b_count", b_out_count, q_b.pop_front());
          check("b_latency", cyc - qe_b.pop_front(), STG_B);
        end
      end
      if (b_in_valid && b_in_ready) begin
        tb = b_in_data ^ {7{b_in_zeros}};
        q_b.push_back($countones(tb)); qe_b.push_back(cyc + 1);
      end
      if (c_out_valid && c_out_ready) begin
        if (q_c.size() == 0) check("c_spurious_out", 1, 0);
        else begin
          check("c_count", c_out_count, q_c.pop_front());
          check("c_latency", cyc - qe_c.pop_front(), STG_C);
        end
      end
      if (c_in_valid && c_in_ready) begin
        tc = c_in_data ^ {64{c_in_zeros}};
        q_c.push_back($countones(tc)); qe_c.push_back(cyc + 1);
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge + 1) ----------------
  task automatic send_a(input logic [31:0] d, input logic z, input logic l);
    int g = 0;
    a_in_valid = 1'b1; a_in_data = d; a_in_zeros = z; a_in_last = l;
    @(negedge clk);
    while (!a_in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("a_send_timeout", 1, 0);
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_last = 1'b0;
  endtask

  task automatic wait_idle_a();
    int g = 0;
    while ((q_a.size() != 0 || a_out_valid) && g < 200) begin
      @(posedge clk);
      g++;
    end
    if (g >= 200) check("a_idle_timeout", 1, 0);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("a_rst_out_valid", a_out_valid, 0);
    check("a_rst_out_count", a_out_count, 0);
    check("a_rst_in_ready", a_in_ready, 1);
    check("b_rst_out_valid", b_out_valid, 0);
    check("c_rst_out_valid", c_out_valid, 0);
    check("c_rst_in_ready", c_in_ready, 1);

    // Single beat, then zeros mode and extremes.
    send_a(32'hF0F0_0001, 1'b0, 1'b0);
    wait_idle_a();
    send_a(32'h0000_0000, 1'b1, 1'b0);
    send_a(32'hFFFF_FFFF, 1'b0, 1'b0);
    send_a(32'hFFFF_FFFF, 1'b1, 1'b0);
    send_a(32'h8000_0001, 1'b1, 1'b0);
    wait_idle_a();

    // Backpressure: five beats with a four-cycle stall in the middle.
    a_lat_chk = 1'b0;
    fork
      begin
        for (int i = 1; i <= 5; i++) send_a((32'h1 << i) - 32'h1, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 a_out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 a_out_ready = 1'b1;
      end
    join
    wait_idle_a();
    a_lat_chk = 1'b1;

    // Reset mid-flight with a beat presented during reset.
    send_a(32'h0000_00FF, 1'b0, 1'b0);
    send_a(32'h0000_FFFF, 1'b0, 1'b0);
    rst = 1'b1; a_in_valid = 1'b1; a_in_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rst = 1'b0; a_in_valid = 1'b0;
    check("a_midrst_out_valid", a_out_valid, 0);
    check("a_midrst_in_ready", a_in_ready, 1);
    check("a_midrst_out_count", a_out_count, 0);
    repeat (8) @(posedge clk);
    #1;
    send_a(32'h0000_0003, 1'b0, 1'b0);
    wait_idle_a();

`ifdef POPCOUNT_PIPE_ACCUM_EN
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    send_a(32'hFFFF_FFFF, 1'b0, 1'b0);
    send_a(32'hFFFF_FFFF, 1'b0, 1'b0);
    send_a(32'hFFFF_FFFF, 1'b0, 1'b1);
    send_a(32'h0000_000F, 1'b0, 1'b1);
    wait_idle_a();
`endif

    // Random sweeps on the odd-width and wide instances.
    for (int i = 0; i < 12500; i++) begin
      b_in_valid = ($urandom_range(0, 4) != 0);
      b_in_data  = 7'($urandom());
      b_in_zeros = 1'($urandom_range(0, 1));
      c_in_valid = ($urandom_range(0, 4) != 0);
      c_in_data  = {$urandom(), $urandom()};
      c_in_zeros = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    c_in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    check("a_drain", q_a.size(), 0);
    check("b_drain", q_b.size(), 0);
    check("c_drain", q_c.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/popcount_pipe.md
Name: popcount_pipe

Overview:
- Parametrised, pipelined population counter. Successor to the 32-input combinational ones-counter.
- Counts set bits (or clear bits, selectable per beat) in a WIDTH-bit word.
- Reduction tree has register stages every LEVELS_PER_STAGE adder levels, so all paths are depth-balanced.
- Streaming valid/ready on both sides. Sits between a sample buffer and the statistics/threshold logic.

Parameters:
- WIDTH, 32: input word width; any value >= 2.
- LEVELS_PER_STAGE, 2: adder-tree levels between pipeline registers; >= 1.
- CNT_W, $clog2(WIDTH+1): count width, derived and not overridable (6 for WIDTH=32).
- ACC_W, 16: accumulator width; used only with POPCOUNT_PIPE_ACCUM_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH  word to count.
- in_zeros  in  1  1 = count zeros, 0 = count ones; sampled with the beat.
- in_last  in  1  frame end; present only with POPCOUNT_PIPE_ACCUM_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_count  out  CNT_W  per-beat count.
- out_acc  out  ACC_W  frame sum; present only with POPCOUNT_PIPE_ACCUM_EN.
- out_sat  out  1  accumulator saturated this frame; present only with POPCOUNT_PIPE_ACCUM_EN.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst. No other clock or reset.
- STAGES = ceil(clog2(WIDTH) / LEVELS_PER_STAGE). The final stage register drives the outputs. For WIDTH=32 and LEVELS_PER_STAGE=2, STAGES=3.
- Latency: a beat accepted at edge N appears on out_valid/out_count after edge N+STAGES when there is no stall.
- Input acceptance: a beat is taken on an edge where in_valid && in_ready.
- in_zeros applies in stage 0: the word counted is in_data XOR {WIDTH{in_zeros}}.
- Stall: global enable, en = !out_valid || out_ready, and in_ready = en.
  - When en=0, every stage register (data and valid) holds.
  - Bubbles are not squeezed out.
- Result handshake: a result is consumed on an edge where out_valid && out_ready. out_count stays stable while out_valid && !out_ready.
- Combinational paths: in_ready depends on out_ready. There is no other input-to-output path.
- Arithmetic:
  - Partial sums at tree level k are k+1 bits wide.
  - Widths not a power of two are zero-padded to the next power of two.
  - No truncation: out_count = WIDTH is representable.
- Reset:
  - All stage valid bits clear; out_valid=0, out_count=0, in_ready=1 on the cycle after rst.
  - Beats in flight are discarded, not flushed.
  - A beat presented during rst is not accepted.
- Simultaneous accept and output: these overlap every cycle at full throughput, one beat per clock.

Optional Feature:
- Macro POPCOUNT_PIPE_ACCUM_EN. When defined:
  - in_last rides the pipeline alongside the count.
  - A frame accumulator is updated when a result is consumed (not on input acceptance): acc = acc + count, saturating at 2^ACC_W-1.
  - out_acc presents acc + out_count, the running sum including the current beat. Saturation sets a sticky flag.
  - out_sat is the sticky flag OR'd with saturation of the current beat.
  - On consumption of a beat with last=1, acc and the sticky flag clear.
  - Reset clears both.
- When undefined: in_last, out_acc and out_sat do not exist, and the block is a pure per-beat counter.

Decomposition:
- Package popcount_pkg holds:
  - the function stages_f(width, lps) returning STAGES;
  - the function cnt_w_f(width);
  - the typedef for the pipeline sideband struct {valid, zeros, last}.
- One sub-module, popcount_tree_lvl: a combinational single tree level that adds pairs of k-bit partials into (k+1)-bit partials. It is instantiated per level by generate and registered at stage boundaries.

Test Plan:
- Single beat: WIDTH=32, in_data=32'hF0F0_0001, in_zeros=0, out_ready=1 → out_count=9 exactly 3 cycles after accept.
- Zeros mode and extremes: in_data=32'h0 with zeros=1 → 32; 32'hFFFF_FFFF with zeros=0 → 32; 32'hFFFF_FFFF with zeros=1 → 0.
- Backpressure: stream 5 beats (popcounts 1,2,3,4,5) with out_ready held low for 4 cycles mid-stream → in_ready=0 while stalled, out_count stable, all 5 results delivered in order, no loss or duplication.
- Reset mid-flight: accept 2 beats, assert rst for 1 cycle → out_valid=0 next cycle, no stale result ever appears, next beat 32'h3 gives 2.
- Parameter sweep: WIDTH=7 with LEVELS_PER_STAGE=1 (3 stages) and WIDTH=64 with LEVELS_PER_STAGE=3 (2 stages), 10k random beats → counts match a reference model and latency equals STAGES.
- Accumulator (with POPCOUNT_PIPE_ACCUM_EN, ACC_W=6): frame of 3 beats of 32'hFFFF_FFFF with last on the 3rd → out_acc=32, then 63 with out_sat=1, then 63 with out_sat=1; the next frame restarts at that beat's count with out_sat=0.
